// File: rtl/parity_frame_ctrl.sv
// parity_frame_ctrl: frames data words with per-word parity and a column-parity trailer
module parity_frame_ctrl #(
  parameter int DATA_W     = 4,
  parameter int FRAME_LEN  = 4,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par,
  output logic              out_last,
  output logic [7:0]        frame_cnt,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, DATA, TRAILER, SENT} state_t;
  state_t state, state_nx;
  logic [7:0] cnt;
  logic [DATA_W-1:0] acc;
  logic slot_free, in_xfer, out_xfer, last_word, load_trl, trl_done;
  // handshake and control strobes derived from state and output slot
  always_comb begin
    slot_free = !out_valid | out_ready;
    in_ready  = slot_free & (state == IDLE | state == DATA);
    in_xfer   = in_valid & in_ready;
    out_xfer  = out_valid & out_ready;
    last_word = in_xfer & (cnt == 8'(FRAME_LEN - 1));
    load_trl  = (state == TRAILER) & slot_free;
    trl_done  = (state == SENT) & out_xfer;
    busy      = (state != IDLE) | out_valid;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next-state: trailer follows the last data word, input reopens after trailer handshake
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_xfer) state_nx = last_word ? TRAILER : DATA;
      DATA:    if (last_word) state_nx = TRAILER;
      TRAILER: if (slot_free) state_nx = SENT;
      SENT:    if (out_xfer) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // word counter, column parity accumulator and completed-frame counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt       <= '0;
      acc       <= '0;
      frame_cnt <= '0;
    end else if (trl_done) begin
      cnt       <= '0;
      acc       <= '0;
      frame_cnt <= frame_cnt + 8'd1;
    end else if (in_xfer) begin
      cnt <= cnt + 8'd1;
      acc <= acc ^ in_data;
    end
  // single output register; holds contents while the sink stalls
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_par   <= 1'b0;
      out_last  <= 1'b0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_par   <= ^in_data ^ ODD_PARITY;
      out_last  <= 1'b0;
    end else if (load_trl) begin
      out_valid <= 1'b1;
      out_data  <= acc;
      out_par   <= ^acc ^ ODD_PARITY;
      out_last  <= 1'b1;
    end else if (slot_free) begin
      out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_parity_frame_ctrl.sv
// tb_parity_frame_ctrl: directed tables plus corner sequences for parity_frame_ctrl
module tb_parity_frame_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0] in_data = '0;
  logic in_ready, out_valid, out_par, out_last, busy;
  logic [3:0] out_data;
  logic [7:0] frame_cnt;
  logic in_ready_o, out_valid_o, out_par_o, out_last_o, busy_o;
  logic [3:0] out_data_o;
  logic [7:0] frame_cnt_o;
  int checks = 0, fails = 0;

  typedef struct packed {logic [3:0] d; logic p; logic po; logic l;} obs_t;
  typedef struct {logic [3:0] din; logic [3:0] dout; logic par; logic last;} vec_t;
  obs_t q[$];
  obs_t exp_q[$];
  vec_t tbl[15];

  parity_frame_ctrl #(.DATA_W(4), .FRAME_LEN(4), .ODD_PARITY(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_par(out_par),
    .out_last(out_last), .frame_cnt(frame_cnt), .busy(busy));

  parity_frame_ctrl #(.DATA_W(4), .FRAME_LEN(4), .ODD_PARITY(1'b1)) dut_o (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o), .in_data(in_data),
    .out_valid(out_valid_o), .out_ready(out_ready), .out_data(out_data_o), .out_par(out_par_o),
    .out_last(out_last_o), .frame_cnt(frame_cnt_o), .busy(busy_o));

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) q.push_back({out_data, out_par, out_par_o, out_last});

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] d);
    int n = 0;
    logic ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    chk("send_accepted", int'(ok), 1);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_idle", int'(busy), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input int base, input bit odd);
    chk("out_count", q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < q.size()) begin
        chk($sformatf("data[%0d]", base + i), int'(q[i].d), int'(tbl[base + i].dout));
        chk($sformatf("par[%0d]", base + i), int'(odd ? q[i].po : q[i].p), int'(tbl[base + i].par));
        chk($sformatf("last[%0d]", base + i), int'(q[i].l), int'(tbl[base + i].last));
      end
  endtask

  task automatic run_frame(input int base, input bit odd);
    q.delete();
    for (int i = 0; i < 4; i++) send(tbl[base + i].din);
    drain();
    cmp(base, odd);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int outs, lasts, nrdy, acc_n, accepted, cyc;
    logic saw255;
    logic [3:0] acc;
    tbl[0]  = '{4'h1, 4'h1, 1'b1, 1'b0};
    tbl[1]  = '{4'h2, 4'h2, 1'b1, 1'b0};
    tbl[2]  = '{4'h3, 4'h3, 1'b0, 1'b0};
    tbl[3]  = '{4'h4, 4'h4, 1'b1, 1'b0};
    tbl[4]  = '{4'h0, 4'h4, 1'b1, 1'b1};
    tbl[5]  = '{4'hF, 4'hF, 1'b1, 1'b0};
    tbl[6]  = '{4'h0, 4'h0, 1'b1, 1'b0};
    tbl[7]  = '{4'hA, 4'hA, 1'b1, 1'b0};
    tbl[8]  = '{4'h5, 4'h5, 1'b1, 1'b0};
    tbl[9]  = '{4'h0, 4'h0, 1'b1, 1'b1};
    tbl[10] = '{4'h8, 4'h8, 1'b1, 1'b0};
    tbl[11] = '{4'h8, 4'h8, 1'b1, 1'b0};
    tbl[12] = '{4'h8, 4'h8, 1'b1, 1'b0};
    tbl[13] = '{4'h8, 4'h8, 1'b1, 1'b0};
    tbl[14] = '{4'h0, 4'h0, 1'b0, 1'b1};

    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_frame(0, 1'b0);
    chk("frame_cnt_1", int'(frame_cnt), 1);

    q.delete();
    send(4'h1);
    send(4'h2);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'h3;
    repeat (3) begin
      @(negedge clk);
      chk("hold_data", int'(out_data), 2);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(4'h3);
    send(4'h4);
    drain();
    cmp(0, 1'b0);
    chk("frame_cnt_2", int'(frame_cnt), 2);

    run_frame(5, 1'b1);
    chk("frame_cnt_3", int'(frame_cnt), 3);

    send(4'h1);
    send(4'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_data", int'(out_data), 0);
    chk("arst_out_par", int'(out_par), 0);
    chk("arst_out_last", int'(out_last), 0);
    chk("arst_frame_cnt", int'(frame_cnt), 0);
    chk("arst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(10, 1'b0);
    chk("frame_cnt_after_rst", int'(frame_cnt), 1);

    reset_pulse();
    outs = 0; lasts = 0; nrdy = 0; saw255 = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int c = 0; c < 256 * 6; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) outs++;
      if (out_valid && out_ready && out_last) lasts++;
      if (!in_ready) nrdy++;
      if (frame_cnt == 8'd255) saw255 = 1'b1;
      in_data = 4'(c);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("stream_outs", outs, 1280);
    chk("stream_lasts", lasts, 256);
    chk("stream_not_ready", nrdy, 512);
    chk("stream_saw_255", int'(saw255), 1);
    chk("stream_wrap", int'(frame_cnt), 0);
    @(posedge clk);
    #1;

    q.delete();
    exp_q.delete();
    acc = '0; acc_n = 0; accepted = 0; cyc = 0;
    while (accepted < 200 && cyc < 8000) begin
      in_valid  = $urandom_range(0, 1) == 1;
      in_data   = 4'($urandom_range(0, 15));
      out_ready = $urandom_range(0, 2) != 0;
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back({in_data, ^in_data, ~^in_data, 1'b0});
        acc = acc ^ in_data;
        acc_n++;
        accepted++;
        if (acc_n == 4) begin
          exp_q.push_back({acc, ^acc, ~^acc, 1'b1});
          acc = '0;
          acc_n = 0;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("rand_count", q.size(), exp_q.size());
    lasts = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i < q.size()) begin
        if (q[i].l) lasts++;
        chk($sformatf("rand_word[%0d]", i), int'(q[i]), int'(exp_q[i]));
      end
    chk("rand_lasts", lasts, 50);
    chk("rand_frame_cnt", int'(frame_cnt), 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
